// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//  Shared encodings for the ID/EX stage: ALU control codes, MIPS primary
//  opcodes and R-type funct fields. It also defines the bundle of decode
//  outputs that alu_ctrl_decode produces.
// ---------------------------------------------------------------------------
package mips_pkg;

   // ALU control codes seen by the downstream ALU
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_MULT = 4'b0010;
   localparam logic [3:0] ALU_DIV  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_AND  = 4'b1000;
   localparam logic [3:0] ALU_OR   = 4'b1001;
   localparam logic [3:0] ALU_XOR  = 4'b1010;
   localparam logic [3:0] ALU_NOR  = 4'b1011;
   localparam logic [3:0] ALU_SLT  = 4'b1110;
   localparam logic [3:0] ALU_NOP  = 4'b1111;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct fields (instr[5:0])
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [5:0] FN_DIV  = 6'b011010;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   // Decoder result bundle
   typedef struct packed {
      logic [3:0] ctrl;       // ALU control code
      logic       b_is_imm;   // operand B comes from the extended immediate
      logic       zext;       // immediate is zero-extended (else sign-extended)
      logic       a_is_rt;    // shifts take operand A from rt
      logic       dst_is_rd;  // destination is rd (else rt)
      logic       we;         // instruction writes a register
      logic       illegal;    // unsupported opcode/funct
   } decode_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
//  Bundles every ID/EX stage signal except clk/rst_n.
//  master : upstream/control side. It drives the decoded ID fields,
//           stall/flush and the two forwarding sources, and reads the
//           EX outputs.
//  slave  : the id_ex_stage itself.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
);
   // ID side
   logic                  id_valid;
   logic [5:0]            id_opcode;
   logic [5:0]            id_funct;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic [REG_ADDR_W-1:0] id_rd;
   logic [4:0]            id_shamt;
   logic [15:0]           id_imm;
   logic [DATA_W-1:0]     id_rs_data;
   logic [DATA_W-1:0]     id_rt_data;
   // pipeline control
   logic                  stall;
   logic                  flush;
   // forwarding sources
   logic                  exmem_we;
   logic [REG_ADDR_W-1:0] exmem_rd;
   logic [DATA_W-1:0]     exmem_data;
   logic                  memwb_we;
   logic [REG_ADDR_W-1:0] memwb_rd;
   logic [DATA_W-1:0]     memwb_data;
   // EX side
   logic                  ex_valid;
   logic [DATA_W-1:0]     ex_a;
   logic [DATA_W-1:0]     ex_b;
   logic [3:0]            ex_alu_ctrl;
   logic [4:0]            ex_shamt;
   logic [REG_ADDR_W-1:0] ex_dst;
   logic                  ex_reg_we;
   logic                  ex_illegal;

   modport master (
      output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt, id_imm,
             id_rs_data, id_rt_data, stall, flush,
             exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
      input  ex_valid, ex_a, ex_b, ex_alu_ctrl, ex_shamt, ex_dst, ex_reg_we, ex_illegal
   );

   modport slave (
      input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt, id_imm,
             id_rs_data, id_rt_data, stall, flush,
             exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
      output ex_valid, ex_a, ex_b, ex_alu_ctrl, ex_shamt, ex_dst, ex_reg_we, ex_illegal
   );
endinterface

// File: rtl/id_ex_stage_alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
//  Purely combinational opcode/funct decoder for the ID/EX stage.
//  Ports:
//   opcode, funct : instruction fields instr[31:26], instr[5:0]
//   dec           : ALU control code plus operand-routing and write flags
//  Unsupported encodings give illegal=1, we=0, ctrl=ALU_NOP.
// ---------------------------------------------------------------------------
module alu_ctrl_decode
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output decode_t    dec
);

   always_comb begin
      dec = '0;
      dec.ctrl = ALU_NOP;
      case (opcode)
         OP_RTYPE: begin
            dec.dst_is_rd = 1'b1;
            dec.we        = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: dec.ctrl = ALU_ADD;
               FN_SUB, FN_SUBU: dec.ctrl = ALU_SUB;
               FN_MULT:         dec.ctrl = ALU_MULT;
               FN_DIV:          dec.ctrl = ALU_DIV;
               FN_SLL: begin
                  dec.ctrl    = ALU_SLL;
                  dec.a_is_rt = 1'b1;
               end
               FN_SRL: begin
                  dec.ctrl    = ALU_SRL;
                  dec.a_is_rt = 1'b1;
               end
               FN_AND:          dec.ctrl = ALU_AND;
               FN_OR:           dec.ctrl = ALU_OR;
               FN_XOR:          dec.ctrl = ALU_XOR;
               FN_NOR:          dec.ctrl = ALU_NOR;
               FN_SLT:          dec.ctrl = ALU_SLT;
               default:         dec.illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin dec.ctrl = ALU_ADD; dec.b_is_imm = 1'b1; dec.we = 1'b1; end
         OP_SLTI: begin dec.ctrl = ALU_SLT; dec.b_is_imm = 1'b1; dec.we = 1'b1; end
         OP_ANDI: begin dec.ctrl = ALU_AND; dec.b_is_imm = 1'b1; dec.zext = 1'b1; dec.we = 1'b1; end
         OP_ORI:  begin dec.ctrl = ALU_OR;  dec.b_is_imm = 1'b1; dec.zext = 1'b1; dec.we = 1'b1; end
         OP_XORI: begin dec.ctrl = ALU_XOR; dec.b_is_imm = 1'b1; dec.zext = 1'b1; dec.we = 1'b1; end
         OP_LW:   begin dec.ctrl = ALU_ADD; dec.b_is_imm = 1'b1; dec.we = 1'b1; end
         OP_SW:   begin dec.ctrl = ALU_ADD; dec.b_is_imm = 1'b1; end
         OP_BEQ:  dec.ctrl = ALU_SUB;
         default: dec.illegal = 1'b1;
      endcase

      // Illegal encodings must never write and present a no-op to the ALU;
      // dst_is_rd is left as decoded so the destination field stays defined.
      if (dec.illegal) begin
         dec.we       = 1'b0;
         dec.ctrl     = ALU_NOP;
         dec.a_is_rt  = 1'b0;
         dec.b_is_imm = 1'b0;
         dec.zext     = 1'b0;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//  ID/EX pipeline register that feeds the ALU. It captures one decoded
//  instruction per cycle, then builds operands A/B and the ALU control code.
//  Forwarding from EX/MEM (higher priority) and MEM/WB is applied
//  combinationally on the registered operand state.
//  Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : id_ex_stage_if.slave. Inputs are the ID fields, stall, flush and
//           the forwarding sources; outputs are the EX operands and controls.
//  Edge priority is flush > stall > capture. A flush kills valid, we and
//  illegal and forces ctrl=NOP, but leaves the operand fields untouched.
// ---------------------------------------------------------------------------
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   id_ex_stage_if.slave bus
);

   decode_t dec;

   alu_ctrl_decode u_decode (
      .opcode (bus.id_opcode),
      .funct  (bus.id_funct),
      .dec    (dec)
   );

   // Capture-side operand selection and immediate extension
   logic [REG_ADDR_W-1:0] a_src_next;
   logic [DATA_W-1:0]     a_data_next;
   logic [DATA_W-1:0]     b_data_next;
   logic [DATA_W-1:0]     imm_ext;

   assign imm_ext     = dec.zext ? {{(DATA_W-16){1'b0}}, bus.id_imm}
                                 : {{(DATA_W-16){bus.id_imm[15]}}, bus.id_imm};
   assign a_src_next  = dec.a_is_rt ? bus.id_rt : bus.id_rs;
   assign a_data_next = dec.a_is_rt ? bus.id_rt_data : bus.id_rs_data;
   assign b_data_next = dec.b_is_imm ? imm_ext : bus.id_rt_data;

   // Pipeline registers
   logic                  valid_reg;
   logic [3:0]            ctrl_reg;
   logic                  we_reg;
   logic                  illegal_reg;
   logic [REG_ADDR_W-1:0] a_src_reg;
   logic [DATA_W-1:0]     a_data_reg;
   logic [REG_ADDR_W-1:0] b_src_reg;
   logic [DATA_W-1:0]     b_data_reg;
   logic                  b_is_imm_reg;
   logic [4:0]            shamt_reg;
   logic [REG_ADDR_W-1:0] dst_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg    <= 1'b0;
         ctrl_reg     <= ALU_NOP;
         we_reg       <= 1'b0;
         illegal_reg  <= 1'b0;
         a_src_reg    <= '0;
         a_data_reg   <= '0;
         b_src_reg    <= '0;
         b_data_reg   <= '0;
         b_is_imm_reg <= 1'b0;
         shamt_reg    <= '0;
         dst_reg      <= '0;
      end else if (bus.flush) begin
         valid_reg   <= 1'b0;
         we_reg      <= 1'b0;
         illegal_reg <= 1'b0;
         ctrl_reg    <= ALU_NOP;
      end else if (!bus.stall) begin
         valid_reg    <= bus.id_valid;
         ctrl_reg     <= dec.ctrl;
         // A non-valid slot can neither write nor trap
         we_reg       <= bus.id_valid & dec.we;
         illegal_reg  <= bus.id_valid & dec.illegal;
         a_src_reg    <= a_src_next;
         a_data_reg   <= a_data_next;
         b_src_reg    <= bus.id_rt;
         b_data_reg   <= b_data_next;
         b_is_imm_reg <= dec.b_is_imm;
         shamt_reg    <= dec.a_is_rt ? bus.id_shamt : 5'd0;
         dst_reg      <= dec.dst_is_rd ? bus.id_rd : bus.id_rt;
      end
   end

   // Forwarding muxes: operand 0 is A, operand 1 is B (register form)
   logic [1:0][REG_ADDR_W-1:0] src_idx;
   logic [1:0][DATA_W-1:0]     src_data;
   logic [1:0][DATA_W-1:0]     fwd_data;

   assign src_idx[0]  = a_src_reg;
   assign src_idx[1]  = b_src_reg;
   assign src_data[0] = a_data_reg;
   assign src_data[1] = b_data_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         logic hit_exmem;
         logic hit_memwb;
         // Register 0 is hard-wired zero and must never pick up forwarded data
         assign hit_exmem = bus.exmem_we && (bus.exmem_rd != '0) && (bus.exmem_rd == src_idx[gi]);
         assign hit_memwb = bus.memwb_we && (bus.memwb_rd != '0) && (bus.memwb_rd == src_idx[gi]);
         assign fwd_data[gi] = hit_exmem ? bus.exmem_data :
                               hit_memwb ? bus.memwb_data : src_data[gi];
      end
   endgenerate

   assign bus.ex_valid    = valid_reg;
   assign bus.ex_a        = fwd_data[0];
   // An immediate operand is not a register value, so it bypasses forwarding
   assign bus.ex_b        = b_is_imm_reg ? b_data_reg : fwd_data[1];
   assign bus.ex_alu_ctrl = ctrl_reg;
   assign bus.ex_shamt    = shamt_reg;
   assign bus.ex_dst      = dst_reg;
   assign bus.ex_reg_we   = valid_reg & we_reg;
   assign bus.ex_illegal  = illegal_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//  Self-checking bench for id_ex_stage: directed scenarios plus randomized
//  traffic, checked against an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   id_ex_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

   id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic        valid;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      logic [31:0] rsd, rtd;
   } ins_t;

   ins_t        drv, cur;
   bit          cur_bubble;
   bit          stall_d, flush_d;
   bit          ew, mw;
   logic [4:0]  erd, mrd;
   logic [31:0] ed, md;
   int          n_cmp = 0;
   int          n_bad = 0;

   // ---- reference model -------------------------------------------------
   function automatic void mdl_decode(input logic [5:0] op, input logic [5:0] fn,
                                      output bit legal, output logic [3:0] code,
                                      output bit shift, output bit imm_b,
                                      output bit zx, output bit wr);
      legal = 1; code = 4'hF; shift = 0; imm_b = 0; zx = 0; wr = 1;
      case (op)
         6'h00: case (fn)
            6'h20, 6'h21: code = 4'h0;
            6'h22, 6'h23: code = 4'h1;
            6'h18: code = 4'h2;
            6'h1A: code = 4'h3;
            6'h00: begin code = 4'h4; shift = 1; end
            6'h02: begin code = 4'h5; shift = 1; end
            6'h24: code = 4'h8;
            6'h25: code = 4'h9;
            6'h26: code = 4'hA;
            6'h27: code = 4'hB;
            6'h2A: code = 4'hE;
            default: legal = 0;
         endcase
         6'h08: begin code = 4'h0; imm_b = 1; end
         6'h0A: begin code = 4'hE; imm_b = 1; end
         6'h0C: begin code = 4'h8; imm_b = 1; zx = 1; end
         6'h0D: begin code = 4'h9; imm_b = 1; zx = 1; end
         6'h0E: begin code = 4'hA; imm_b = 1; zx = 1; end
         6'h23: begin code = 4'h0; imm_b = 1; end
         6'h2B: begin code = 4'h0; imm_b = 1; wr = 0; end
         6'h04: begin code = 4'h1; wr = 0; end
         default: legal = 0;
      endcase
      if (!legal) begin code = 4'hF; shift = 0; imm_b = 0; zx = 0; wr = 0; end
   endfunction

   function automatic logic [31:0] mdl_fwd(input logic [4:0] idx, input logic [31:0] raw);
      if (ew && erd != 0 && erd == idx) return ed;
      if (mw && mrd != 0 && mrd == idx) return md;
      return raw;
   endfunction

   // {valid, a, b, ctrl, shamt, dst, reg_we, illegal}
   function automatic logic [80:0] model_out();
      bit legal, shift, imm_b, zx, wr, v;
      logic [3:0]  code;
      logic [31:0] a, b;
      mdl_decode(cur.op, cur.fn, legal, code, shift, imm_b, zx, wr);
      a = shift ? mdl_fwd(cur.rt, cur.rtd) : mdl_fwd(cur.rs, cur.rsd);
      if (imm_b) b = zx ? {16'h0, cur.imm} : {{16{cur.imm[15]}}, cur.imm};
      else       b = mdl_fwd(cur.rt, cur.rtd);
      v = cur.valid && !cur_bubble;
      return {v, a, b, cur_bubble ? 4'hF : code, shift ? cur.sh : 5'd0,
              (cur.op == 6'h00) ? cur.rd : cur.rt, v && wr, v && !legal};
   endfunction

   function automatic logic [80:0] obs();
      return {bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_alu_ctrl, bus.ex_shamt,
              bus.ex_dst, bus.ex_reg_we, bus.ex_illegal};
   endfunction

   // ---- stimulus plumbing -----------------------------------------------
   task automatic apply();
      bus.id_valid = drv.valid;   bus.id_opcode = drv.op;   bus.id_funct = drv.fn;
      bus.id_rs = drv.rs;         bus.id_rt = drv.rt;       bus.id_rd = drv.rd;
      bus.id_shamt = drv.sh;      bus.id_imm = drv.imm;
      bus.id_rs_data = drv.rsd;   bus.id_rt_data = drv.rtd;
      bus.stall = stall_d;        bus.flush = flush_d;
      bus.exmem_we = ew;          bus.exmem_rd = erd;       bus.exmem_data = ed;
      bus.memwb_we = mw;          bus.memwb_rd = mrd;       bus.memwb_data = md;
   endtask

   task automatic fwd_off();
      ew = 0; erd = 0; ed = 0; mw = 0; mrd = 0; md = 0;
   endtask

   task automatic step();
      @(posedge clk);
      if (flush_d) cur_bubble = 1;
      else if (!stall_d) begin cur = drv; cur_bubble = 0; end
      #1;
   endtask

   function automatic ins_t mk(input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] sh,
                               input logic [15:0] imm, input logic [31:0] rsd,
                               input logic [31:0] rtd);
      ins_t t;
      t.valid = 1; t.op = op; t.fn = fn; t.rs = rs; t.rt = rt; t.rd = rd;
      t.sh = sh; t.imm = imm; t.rsd = rsd; t.rtd = rtd;
      return t;
   endfunction

   // ---- scenarios -------------------------------------------------------
   task automatic test_reset();
      n_cmp++;
      if (bus.ex_valid !== 1'b0 || bus.ex_a !== 32'd0 || bus.ex_b !== 32'd0 ||
          bus.ex_alu_ctrl !== 4'hF || bus.ex_reg_we !== 1'b0 || bus.ex_illegal !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: got %h want %h", obs(), {1'b0, 64'd0, 4'hF, 12'd0});
      end
      $display("txn reset: outputs %h", obs());
   endtask

   task automatic test_add();
      fwd_off(); stall_d = 0; flush_d = 0;
      drv = mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7);
      apply(); step();
      n_cmp++;
      if (bus.ex_a !== 32'd5 || bus.ex_b !== 32'd7 || bus.ex_alu_ctrl !== 4'h0 ||
          bus.ex_dst !== 5'd3 || bus.ex_reg_we !== 1'b1 || bus.ex_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL add: got a=%h b=%h ctrl=%h dst=%0d we=%b want a=5 b=7 ctrl=0 dst=3 we=1",
                  bus.ex_a, bus.ex_b, bus.ex_alu_ctrl, bus.ex_dst, bus.ex_reg_we);
      end
      $display("txn add r3,r1,r2: a=%h b=%h", bus.ex_a, bus.ex_b);
   endtask

   task automatic test_extend();
      drv = mk(6'h08, 6'h3F, 5'd1, 5'd6, 5'd0, 5'd0, 16'hFFFF, 32'd1, 32'd2);
      apply(); step();
      n_cmp++;
      if (bus.ex_b !== 32'hFFFF_FFFF || bus.ex_alu_ctrl !== 4'h0 || bus.ex_dst !== 5'd6) begin
         n_bad++;
         $display("FAIL addi_sext: got b=%h ctrl=%h dst=%0d want b=ffffffff ctrl=0 dst=6",
                  bus.ex_b, bus.ex_alu_ctrl, bus.ex_dst);
      end
      $display("txn addi imm=ffff: b=%h", bus.ex_b);
      drv = mk(6'h0D, 6'h00, 5'd1, 5'd6, 5'd0, 5'd0, 16'hFFFF, 32'd1, 32'd2);
      apply(); step();
      n_cmp++;
      if (bus.ex_b !== 32'h0000_FFFF || bus.ex_alu_ctrl !== 4'h9) begin
         n_bad++;
         $display("FAIL ori_zext: got b=%h ctrl=%h want b=0000ffff ctrl=9", bus.ex_b, bus.ex_alu_ctrl);
      end
      $display("txn ori imm=ffff: b=%h", bus.ex_b);
   endtask

   task automatic test_shift();
      drv = mk(6'h00, 6'h00, 5'd9, 5'd2, 5'd4, 5'd3, 16'h0, 32'h55, 32'd1);
      apply(); step();
      n_cmp++;
      if (bus.ex_a !== 32'd1 || bus.ex_shamt !== 5'd3 || bus.ex_alu_ctrl !== 4'h4 ||
          bus.ex_dst !== 5'd4) begin
         n_bad++;
         $display("FAIL sll: got a=%h sh=%0d ctrl=%h dst=%0d want a=1 sh=3 ctrl=4 dst=4",
                  bus.ex_a, bus.ex_shamt, bus.ex_alu_ctrl, bus.ex_dst);
      end
      $display("txn sll r4,r2,3: a=%h shamt=%0d", bus.ex_a, bus.ex_shamt);
   endtask

   task automatic test_forward();
      drv = mk(6'h00, 6'h20, 5'd2, 5'd5, 5'd7, 5'd0, 16'h0, 32'h11, 32'h22);
      apply(); step();
      ew = 1; erd = 2; ed = 32'hAA; mw = 1; mrd = 2; md = 32'hBB; apply(); #1;
      n_cmp++;
      if (bus.ex_a !== 32'hAA) begin
         n_bad++; $display("FAIL fwd_exmem_wins: got a=%h want aa", bus.ex_a);
      end
      ew = 0; apply(); #1;
      n_cmp++;
      if (bus.ex_a !== 32'hBB) begin
         n_bad++; $display("FAIL fwd_memwb: got a=%h want bb", bus.ex_a);
      end
      ew = 1; erd = 5; ed = 32'hCC; apply(); #1;
      n_cmp++;
      if (bus.ex_b !== 32'hCC || bus.ex_a !== 32'hBB) begin
         n_bad++; $display("FAIL fwd_b_rt: got a=%h b=%h want a=bb b=cc", bus.ex_a, bus.ex_b);
      end
      $display("txn forward: a=%h b=%h", bus.ex_a, bus.ex_b);
      // immediate B must ignore a matching forward source
      drv = mk(6'h08, 6'h00, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0010, 32'h0, 32'h99);
      ew = 1; erd = 5; ed = 32'hDEAD; mw = 1; mrd = 5; md = 32'hBEEF; apply(); step();
      n_cmp++;
      if (bus.ex_b !== 32'h10) begin
         n_bad++; $display("FAIL fwd_imm_blocked: got b=%h want 10", bus.ex_b);
      end
      // index 0 never forwards
      drv = mk(6'h00, 6'h20, 5'd0, 5'd0, 5'd1, 5'd0, 16'h0, 32'h0, 32'h0);
      ew = 1; erd = 0; ed = 32'h77; mw = 1; mrd = 0; md = 32'h66; apply(); step();
      n_cmp++;
      if (bus.ex_a !== 32'd0 || bus.ex_b !== 32'd0) begin
         n_bad++; $display("FAIL fwd_r0: got a=%h b=%h want 0 0", bus.ex_a, bus.ex_b);
      end
      $display("txn forward r0: a=%h", bus.ex_a);
      fwd_off(); apply();
   endtask

   task automatic test_stall_flush();
      drv = mk(6'h00, 6'h25, 5'd1, 5'd2, 5'd8, 5'd0, 16'h0, 32'h1234, 32'h5678);
      apply(); step();
      stall_d = 1;
      for (int i = 0; i < 3; i++) begin
         drv = mk(6'h00, 6'h22, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                  5'($urandom_range(1, 31)), 5'd0, 16'($urandom), $urandom, $urandom);
         apply(); step();
         n_cmp++;
         if (bus.ex_a !== 32'h1234 || bus.ex_b !== 32'h5678 || bus.ex_alu_ctrl !== 4'h9 ||
             bus.ex_dst !== 5'd8 || bus.ex_valid !== 1'b1 || bus.ex_reg_we !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_hold%0d: got %h want a=1234 b=5678 ctrl=9 dst=8", i, obs());
         end
         $display("txn stall %0d: %h", i, obs());
      end
      flush_d = 1; apply(); step();
      n_cmp++;
      if (bus.ex_valid !== 1'b0 || bus.ex_reg_we !== 1'b0 || bus.ex_alu_ctrl !== 4'hF ||
          bus.ex_illegal !== 1'b0 || bus.ex_a !== 32'h1234 || bus.ex_dst !== 5'd8) begin
         n_bad++;
         $display("FAIL flush_stall: got %h want valid=0 we=0 ctrl=f a=1234 dst=8", obs());
      end
      $display("txn flush+stall: %h", obs());
      stall_d = 0; flush_d = 0; apply();
   endtask

   task automatic test_illegal();
      drv = mk(6'h3F, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd1, 32'd2);
      apply(); step();
      n_cmp++;
      if (bus.ex_illegal !== 1'b1 || bus.ex_reg_we !== 1'b0 || bus.ex_alu_ctrl !== 4'hF) begin
         n_bad++;
         $display("FAIL illegal_op: got ill=%b we=%b ctrl=%h want 1 0 f",
                  bus.ex_illegal, bus.ex_reg_we, bus.ex_alu_ctrl);
      end
      drv = mk(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd1, 32'd2);
      apply(); step();
      n_cmp++;
      if (bus.ex_illegal !== 1'b1 || bus.ex_reg_we !== 1'b0 || bus.ex_alu_ctrl !== 4'hF) begin
         n_bad++;
         $display("FAIL illegal_funct: got ill=%b we=%b ctrl=%h want 1 0 f",
                  bus.ex_illegal, bus.ex_reg_we, bus.ex_alu_ctrl);
      end
      drv = mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd1, 32'd2);
      drv.valid = 0;
      apply(); step();
      n_cmp++;
      if (bus.ex_valid !== 1'b0 || bus.ex_reg_we !== 1'b0 || bus.ex_illegal !== 1'b0) begin
         n_bad++;
         $display("FAIL invalid_slot: got v=%b we=%b ill=%b want 0 0 0",
                  bus.ex_valid, bus.ex_reg_we, bus.ex_illegal);
      end
      $display("txn illegal/invalid: %h", obs());
   endtask

   task automatic test_async_reset();
      drv = mk(6'h00, 6'h20, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 32'h42, 32'h43);
      apply(); step();
      #2 rst_n = 0;
      #1;
      cur = '0; cur_bubble = 1;
      n_cmp++;
      if (bus.ex_valid !== 1'b0 || bus.ex_a !== 32'd0 || bus.ex_b !== 32'd0 ||
          bus.ex_reg_we !== 1'b0 || bus.ex_alu_ctrl !== 4'hF) begin
         n_bad++;
         $display("FAIL async_reset: got v=%b a=%h b=%h we=%b ctrl=%h want 0 0 0 0 f",
                  bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_reg_we, bus.ex_alu_ctrl);
      end
      #1 rst_n = 1;
      #1;
      n_cmp++;
      if (obs() !== model_out()) begin
         n_bad++; $display("FAIL reset_release: got %h want %h", obs(), model_out());
      end
      $display("txn async reset: %h", obs());
   endtask

   task automatic test_random();
      logic [5:0] ops [11] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C,
                               6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04};
      logic [5:0] fns [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h18, 6'h1A, 6'h00,
                               6'h02, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
      for (int n = 0; n < 300; n++) begin
         drv.valid = ($urandom_range(0, 9) != 0);
         drv.op    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
         drv.fn    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 12)];
         drv.rs    = 5'($urandom_range(0, 3));
         drv.rt    = 5'($urandom_range(0, 3));
         drv.rd    = 5'($urandom);
         drv.sh    = 5'($urandom);
         drv.imm   = 16'($urandom);
         drv.rsd   = $urandom;
         drv.rtd   = $urandom;
         stall_d   = ($urandom_range(0, 7) == 0);
         flush_d   = ($urandom_range(0, 9) == 0);
         ew = 1'($urandom); erd = 5'($urandom_range(0, 3)); ed = $urandom;
         mw = 1'($urandom); mrd = 5'($urandom_range(0, 3)); md = $urandom;
         apply(); step();
         n_cmp++;
         if (obs() !== model_out()) begin
            n_bad++;
            $display("FAIL random%0d: got %h want %h (op=%h fn=%h st=%b fl=%b)",
                     n, obs(), model_out(), drv.op, drv.fn, stall_d, flush_d);
         end
         $display("txn rnd %0d op=%h fn=%h st=%b fl=%b out=%h", n, drv.op, drv.fn,
                  stall_d, flush_d, obs());
      end
      stall_d = 0; flush_d = 0; fwd_off(); apply();
   endtask

   initial begin
      rst_n = 0;
      drv = '0; stall_d = 0; flush_d = 0; fwd_off(); apply();
      cur = '0; cur_bubble = 1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1;
      test_add();
      test_extend();
      test_shift();
      test_forward();
      test_stall_flush();
      test_illegal();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
